// File: rtl/tile_geom_pkg.sv
// Shared geometry defaults and FSM encoding for the tile-to-raster writer
// and anything else that addresses the same frame buffer.
package tile_geom_pkg;

  localparam int TG_DATA_WIDTH  = 8;
  localparam int TG_IMG_WIDTH   = 32;
  localparam int TG_IMG_HEIGHT  = 16;
  localparam int TG_TILE_WIDTH  = 16;
  localparam int TG_TILE_HEIGHT = 16;

  typedef enum logic [1:0] {
    ST_WRITE = 2'd0,
    ST_READ  = 2'd1,
    ST_DONE  = 2'd2
  } tile_state_e;

  // Counter width that stays legal for a range of one value.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tile_frame_ram.sv
// Simple dual-port frame buffer: one write port, one read port with a
// one-cycle registered read. Pure storage, no control.
module tile_frame_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 9,
  parameter int DEPTH      = 512
) (
  input  logic                  iClk,
  input  logic                  iWe,
  input  logic [ADDR_W-1:0]     iWrAddr,
  input  logic [DATA_WIDTH-1:0] iWrData,
  input  logic [ADDR_W-1:0]     iRdAddr,
  output logic [DATA_WIDTH-1:0] oRdData
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge iClk) begin
    if (iWe) begin
      mem_q[iWrAddr] <= iWrData;
    end
  end

  always_ff @(posedge iClk) begin
    rd_q <= mem_q[iRdAddr];
  end

  assign oRdData = rd_q;

endmodule

// File: rtl/tile_raster_writer.sv
// Collects one frame arriving in tile order into a frame buffer, then
// streams it back out in raster order and pulses oDone.
module tile_raster_writer
  import tile_geom_pkg::*;
#(
  parameter int DATA_WIDTH  = TG_DATA_WIDTH,
  parameter int IMG_WIDTH   = TG_IMG_WIDTH,
  parameter int IMG_HEIGHT  = TG_IMG_HEIGHT,
  parameter int TILE_WIDTH  = TG_TILE_WIDTH,
  parameter int TILE_HEIGHT = TG_TILE_HEIGHT
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic                  iValid,
  output logic                  oReady,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oValid,
  output logic                  oLast,
  output logic                  oDone
);

  localparam int NPIX    = IMG_WIDTH * IMG_HEIGHT;
  localparam int ADDR_W  = cnt_w(NPIX);
  localparam int TILES_X = IMG_WIDTH / TILE_WIDTH;
  localparam int TILES_Y = IMG_HEIGHT / TILE_HEIGHT;
  localparam int CW      = cnt_w(TILE_WIDTH);
  localparam int RW      = cnt_w(TILE_HEIGHT);
  localparam int TXW     = cnt_w(TILES_X);
  localparam int TYW     = cnt_w(TILES_Y);

  tile_state_e state_q, state_d;

  logic [CW-1:0]     c_q, c_d;
  logic [RW-1:0]     r_q, r_d;
  logic [TXW-1:0]    tx_q, tx_d;
  logic [TYW-1:0]    ty_q, ty_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_all_q, rd_all_d;
  logic              vld_q, last_q;

  logic              ram_we;
  logic              rd_en;
  logic              accept;
  logic              c_max, r_max, tx_max, ty_max, frame_end;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  assign c_max     = (c_q  == CW'(TILE_WIDTH - 1));
  assign r_max     = (r_q  == RW'(TILE_HEIGHT - 1));
  assign tx_max    = (tx_q == TXW'(TILES_X - 1));
  assign ty_max    = (ty_q == TYW'(TILES_Y - 1));
  assign accept    = iValid && oReady;
  assign frame_end = accept && c_max && r_max && tx_max && ty_max;

  assign wr_addr = (ADDR_W'(ty_q) * ADDR_W'(TILE_HEIGHT) + ADDR_W'(r_q)) * ADDR_W'(IMG_WIDTH)
                 + ADDR_W'(tx_q) * ADDR_W'(TILE_WIDTH) + ADDR_W'(c_q);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_WRITE;
    end else begin
      state_q <= state_d;
    end
  end

  // READ ends only once the final pixel has left the output register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WRITE: if (frame_end) state_d = ST_READ;
      ST_READ:  if (last_q)    state_d = ST_DONE;
      ST_DONE:                 state_d = ST_WRITE;
      default:                 state_d = ST_WRITE;
    endcase
  end

  always_comb begin
    oReady = (state_q == ST_WRITE);
    oDone  = (state_q == ST_DONE);
    ram_we = (state_q == ST_WRITE) && iValid && !iRst;
    rd_en  = (state_q == ST_READ) && !rd_all_q;
  end

  always_comb begin
    c_d       = c_q;
    r_d       = r_q;
    tx_d      = tx_q;
    ty_d      = ty_q;
    rd_addr_d = rd_addr_q;
    rd_all_d  = rd_all_q;
    if (state_q == ST_DONE) begin
      c_d       = '0;
      r_d       = '0;
      tx_d      = '0;
      ty_d      = '0;
      rd_addr_d = '0;
      rd_all_d  = 1'b0;
    end else if (accept) begin
      c_d = c_max ? '0 : c_q + 1'b1;
      if (c_max) begin
        r_d = r_max ? '0 : r_q + 1'b1;
        if (r_max) begin
          tx_d = tx_max ? '0 : tx_q + 1'b1;
          if (tx_max) begin
            ty_d = ty_max ? '0 : ty_q + 1'b1;
          end
        end
      end
    end else if (rd_en) begin
      rd_addr_d = rd_addr_q + 1'b1;
      if (rd_addr_q == ADDR_W'(NPIX - 1)) begin
        rd_all_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      c_q       <= '0;
      r_q       <= '0;
      tx_q      <= '0;
      ty_q      <= '0;
      rd_addr_q <= '0;
      rd_all_q  <= 1'b0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      c_q       <= c_d;
      r_q       <= r_d;
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      rd_addr_q <= rd_addr_d;
      rd_all_q  <= rd_all_d;
      vld_q     <= rd_en;
      last_q    <= rd_en && (rd_addr_q == ADDR_W'(NPIX - 1));
    end
  end

  tile_frame_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W),
    .DEPTH      (NPIX)
  ) u_ram (
    .iClk    (iClk),
    .iWe     (ram_we),
    .iWrAddr (wr_addr),
    .iWrData (iData),
    .iRdAddr (rd_addr_q),
    .oRdData (ram_rd_data)
  );

  // The RAM read register is not reset, so the data port is masked by valid.
  assign oData  = vld_q ? ram_rd_data : '0;
  assign oValid = vld_q;
  assign oLast  = last_q;

endmodule

// File: doc/tile_raster_writer.md
TILE_RASTER_WRITER -- requirements
Module: tile_raster_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 32, frame width in pixels.
REQ-003 SHALL have parameter IMG_HEIGHT, default 16, frame height in pixels.
REQ-004 SHALL have parameter TILE_WIDTH, default 16, tile width in pixels; IMG_WIDTH is a multiple of it.
REQ-005 SHALL have parameter TILE_HEIGHT, default 16, tile height in pixels; IMG_HEIGHT is a multiple of it.
REQ-006 SHALL have port iClk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port iRst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port iData, input, DATA_WIDTH, tile-ordered input pixel.
REQ-009 SHALL have port iValid, input, 1, iData is valid this cycle.
REQ-010 SHALL have port oReady, output, 1, block accepts input this cycle.
REQ-011 SHALL have port oData, output, DATA_WIDTH, raster-ordered output pixel.
REQ-012 SHALL have port oValid, output, 1, oData is valid this cycle.
REQ-013 SHALL have port oLast, output, 1, high with the final oValid pixel of a frame.
REQ-014 SHALL have port oDone, output, 1, one-cycle pulse after a frame readout completes.

Function
REQ-015 SHALL implement states WRITE, READ, DONE; WRITE is the reset state.
REQ-016 SHALL drive oReady=1 only in WRITE; an input beat is accepted when iValid && oReady.
REQ-017 SHALL order input tiles tile-row-major: tiles left to right, then tile rows top to bottom; pixels raster order inside each tile.
REQ-018 SHALL track in-tile column c, in-tile row r, tile column tx and tile row ty; c wraps at TILE_WIDTH-1 and increments r; r wraps at TILE_HEIGHT-1 and increments tx; tx wraps at IMG_WIDTH/TILE_WIDTH-1 and increments ty.
REQ-019 SHALL write each accepted pixel at address (ty*TILE_HEIGHT+r)*IMG_WIDTH + tx*TILE_WIDTH + c; address width is clog2(IMG_WIDTH*IMG_HEIGHT) (9 bits at defaults).
REQ-020 SHALL hold all counters when iValid=0 in WRITE; gaps of any length are legal.
REQ-021 SHALL move from WRITE to READ on the cycle after the beat with c, r, tx, ty all at maximum is accepted.
REQ-022 SHALL ignore iValid in READ and DONE; no RAM write occurs.
REQ-023 SHALL in READ issue read addresses 0..IMG_WIDTH*IMG_HEIGHT-1, one per cycle, with no gaps and no backpressure.
REQ-024 SHALL register RAM output: oValid/oData follow the read address by exactly 1 cycle.
REQ-025 SHALL assert oLast with the pixel from the final address only.
REQ-026 SHALL enter DONE after the final address is issued, once its pixel is output.
REQ-027 SHALL pulse oDone high for exactly one cycle in DONE, then return to WRITE with all counters zero.
REQ-028 SHALL make the first READ pixel reflect the last WRITE beat; no read-before-write hazard is permitted.

Reset
REQ-029 SHALL on iRst=1 force state WRITE, clear all counters, and drive oValid=0, oLast=0, oDone=0, oData=0, and oReady=1 from the next cycle.
REQ-030 SHALL abandon any partial frame when reset is asserted mid-WRITE or mid-READ; RAM contents are not cleared and are not required to be.

Structure
REQ-031 SHALL take geometry defaults and the state encoding from shared package tile_geom_pkg; Bram_interface uses the same constants.
REQ-032 SHALL instantiate one sub-module, tile_frame_ram: simple dual-port RAM with one write port, one read port and 1-cycle registered read.
REQ-033 SHALL keep address generation and the FSM in tile_raster_writer; tile_frame_ram contains no control logic.

Verification
REQ-034 SHALL cover frame ordering: a full frame with iValid=1 continuously and iData = tile-order index mod 256 -> 512 oValid beats, raster pixel (y,x) = tile-order index of (y,x); pixel (0,16) = 0x00 (index 256 mod 256); pixel (1,0) = 0x10.
REQ-035 SHALL cover input gaps: the same frame with iValid randomly low 50% of cycles -> output identical to REQ-034.
REQ-036 SHALL cover input in READ: iValid=1 with iData=0xFF held during READ -> no RAM change; the next frame is unaffected.
REQ-037 SHALL cover timing: oReady=0 the cycle after the final write; first oValid exactly 2 cycles after the final write; oLast on beat 512; oDone one cycle later; oReady=1 on the following cycle.
REQ-038 SHALL cover reset mid-frame: iRst pulsed after 100 input beats, then a full new frame -> output matches the new frame only; oDone=0 during reset.
REQ-039 SHALL cover back-to-back frames: two frames with distinct patterns -> two correct readouts, exactly two oDone pulses.
